// File: rtl/if_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
// Provides the default reset PC, bubble word, FSM state enum and IF/ID bundle.
package if_pkg;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP_INST = 32'h0000_0000;

   typedef enum logic [0:0] {
      RUN      = 1'b0,
      REDIRECT = 1'b1
   } if_state_t;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc_4;
      logic        valid;
   } if_id_t;

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and imem (slave).
// Signals: imem_req/imem_addr from fetch, imem_rdata/imem_ready from memory.
interface if_stage_if;

   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_ready;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_rdata,
      input  imem_ready
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_rdata,
      output imem_ready
   );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with hold, bubble-load and normal-load controls.
// Ports: clk, rst_n, hold_i > bubble_i > load_i, d_i bundle in, q_o bundle out.
module if_id_reg
   import if_pkg::*;
#(
   parameter logic [31:0] BUBBLE_INST = NOP_INST
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   hold_i,
   input  logic   bubble_i,
   input  logic   load_i,
   input  if_id_t d_i,
   output if_id_t q_o
);

   if_id_t ifid_q;
   if_id_t ifid_d;
   if_id_t bubble;

   assign bubble = '{inst: BUBBLE_INST, pc_4: 32'd0, valid: 1'b0};

   always_comb begin
      ifid_d = ifid_q;
      if (hold_i)
         ifid_d = ifid_q;
      else if (bubble_i)
         ifid_d = bubble;
      else if (load_i)
         ifid_d = d_i;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ifid_q <= bubble;
      else
         ifid_q <= ifid_d;
   end

   assign q_o = ifid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC, redirect FSM and IF/ID register feeding decode.
// Ports: clk, rst_n, imem bus (master), stall, branch_taken/target,
// id_inst, id_pc_4, id_valid. Optional MIPS delay slot: IF_DELAY_SLOT_EN.
module if_stage #(
   parameter logic [31:0] RESET_PC = if_pkg::RESET_PC,
   parameter logic [31:0] NOP_INST = if_pkg::NOP_INST
) (
   input  logic               clk,
   input  logic               rst_n,
   if_stage_if.master         imem,
   input  logic               stall,
   input  logic               branch_taken,
   input  logic [31:0]        branch_target,
   output logic [31:0]        id_inst,
   output logic [31:0]        id_pc_4,
   output logic               id_valid
);

   import if_pkg::*;

   localparam logic [0:0] S_RUN   = RUN;
   localparam logic [0:0] S_REDIR = REDIRECT;

   logic [31:0] pc_q, pc_d;
   logic [31:0] redir_q, redir_d;
   logic [0:0]  st_q, st_d;
   logic [31:0] pc_4;
   logic        hold, bub, load;
   if_id_t      ifid_d;
   if_id_t      ifid_q;

   assign pc_4 = pc_q + 32'd4;

   always_comb begin
      pc_d    = pc_q;
      redir_d = redir_q;
      st_d    = st_q;
      hold    = 1'b0;
      bub     = 1'b0;
      load    = 1'b0;
      unique case (st_q)
         S_RUN: begin
            if (branch_taken) begin
               // Without ready the access in flight keeps its address;
               // the target is parked until that access retires.
               if (imem.imem_ready) begin
                  pc_d = branch_target;
               end else begin
                  redir_d = branch_target;
                  st_d    = S_REDIR;
               end
`ifdef IF_DELAY_SLOT_EN
               if (stall)
                  hold = 1'b1;
               else if (imem.imem_ready)
                  load = 1'b1;
               else
                  bub = 1'b1;
`else
               bub = 1'b1;
`endif
            end else if (stall) begin
               hold = 1'b1;
            end else if (imem.imem_ready) begin
               load = 1'b1;
               pc_d = pc_4;
            end else begin
               bub = 1'b1;
            end
         end
         S_REDIR: begin
            if (imem.imem_ready) begin
               pc_d = redir_q;
               st_d = S_RUN;
`ifdef IF_DELAY_SLOT_EN
               load = 1'b1;
`else
               bub = 1'b1;
`endif
            end else begin
               bub = 1'b1;
            end
         end
         default: begin
            st_d = S_RUN;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q    <= RESET_PC;
         redir_q <= 32'd0;
         st_q    <= S_RUN;
      end else begin
         pc_q    <= pc_d;
         redir_q <= redir_d;
         st_q    <= st_d;
      end
   end

   assign ifid_d = '{inst: imem.imem_rdata, pc_4: pc_4, valid: 1'b1};

   if_id_reg #(
      .BUBBLE_INST(NOP_INST)
   ) u_if_id (
      .clk      (clk),
      .rst_n    (rst_n),
      .hold_i   (hold),
      .bubble_i (bub),
      .load_i   (load),
      .d_i      (ifid_d),
      .q_o      (ifid_q)
   );

   assign imem.imem_req  = rst_n;
   assign imem.imem_addr = pc_q;
   assign id_inst        = ifid_q.inst;
   assign id_pc_4        = ifid_q.pc_4;
   assign id_valid       = ifid_q.valid;

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the 5-stage pipeline, directly upstream of the decode stage. It owns the PC register and drives the instruction-memory address. It holds the IF/ID pipeline register that supplies `id_inst` and `id_pc_4` to decode. It absorbs hazard-unit stalls, branch redirects from decode and multi-cycle instruction-memory latency.

## Interface

Parameters:
- `RESET_PC`: default 32'h0000_0000. PC value loaded at reset.
- `NOP_INST`: default 32'h0000_0000. Instruction word injected as a bubble (`sll $0,$0,0`).

Ports (clock and reset first):
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `imem_req`  out  1  — fetch request. 1 in every cycle outside reset.
- `imem_addr`  out  32  — fetch address. Equals the PC register in RUN, and the held old PC in REDIRECT.
- `imem_rdata`  in  32  — instruction word. Valid only when `imem_ready`=1.
- `imem_ready`  in  1  — memory has completed the access at `imem_addr` this cycle.
- `stall`  in  1  — hazard unit: hold PC and IF/ID.
- `branch_taken`  in  1  — decode resolved a taken branch or jump this cycle.
- `branch_target`  in  32  — redirect address, qualified by `branch_taken`.
- `id_inst`  out  32  — IF/ID instruction register.
- `id_pc_4`  out  32  — IF/ID register holding the fetched PC + 4.
- `id_valid`  out  1  — IF/ID holds a real instruction; 0 means bubble.

## Operation

- State machine has 2 states: RUN and REDIRECT. Registers: `pc`, `redir_pc`, and the IF/ID trio.
- Priority within a cycle: reset > `branch_taken` > `stall` > `imem_ready`.
- RUN, `branch_taken`=1, `imem_ready`=1:
  - `pc` ← `branch_target`.
  - IF/ID takes a bubble, or the fetched word when DELAY_SLOT_EN is defined (see Configuration).
  - State stays RUN.
- RUN, `branch_taken`=1, `imem_ready`=0:
  - `redir_pc` ← `branch_target`.
  - `pc` is unchanged, so the outstanding access completes on its original address.
  - IF/ID takes a bubble. Next state is REDIRECT.
- RUN, `stall`=1, `branch_taken`=0:
  - `pc` and IF/ID hold.
  - Any returned word is dropped and refetched later (same address).
- RUN, `imem_ready`=1, no stall, no branch:
  - IF/ID ← {`imem_rdata`, `pc`+4, valid=1}.
  - `pc` ← `pc`+4.
- RUN, `imem_ready`=0, no stall, no branch: `pc` holds; IF/ID takes a bubble.
- REDIRECT:
  - `branch_taken` and `stall` are ignored.
  - The state waits for `imem_ready`=1. On that edge, `pc` ← `redir_pc` and the state returns to RUN.
  - The returned word is dropped as a bubble, or delivered when DELAY_SLOT_EN is defined.
- Bubble means: `id_inst`=`NOP_INST`, `id_pc_4`=0, `id_valid`=0.
- Arithmetic: `pc`+4 is 32-bit and wraps modulo 2^32 (32'hFFFF_FFFC → 32'h0000_0000). The low 2 bits of `branch_target` are passed through unchanged; no alignment check is made.

## Timing

- Reset values (async assert, applied immediately):
  - `pc`=`RESET_PC`, `redir_pc`=0, state=RUN.
  - `id_inst`=`NOP_INST`, `id_pc_4`=0, `id_valid`=0.
  - `imem_req`=0 while `rst_n`=0.
- Reset deassertion is synchronized externally. The first request goes out in the first cycle after release, with `imem_addr`=`RESET_PC`.
- Latency: with a zero-wait memory, an instruction appears at `id_inst` 1 cycle after its address is on `imem_addr`. Throughput is 1 instruction per cycle.
- A reset asserted mid-REDIRECT discards `redir_pc` and the in-flight access. The memory must tolerate an abandoned request.
- `stall` held for N cycles keeps `id_inst`/`id_pc_4`/`id_valid` bit-identical for N cycles.

## Configuration

- `IF_DELAY_SLOT_EN` defined: MIPS branch delay slot.
  - The instruction fetched in the redirect cycle (RUN with `imem_ready`=1) is written to IF/ID as valid.
  - In REDIRECT, the completing word is delivered as valid.
  - If `branch_taken` and `stall` are both 1 in RUN, IF/ID holds instead of taking a bubble.
- Not defined: every fetch in flight at redirect is squashed to a bubble.

## Structure

- Shared package `if_pkg`:
  - `NOP_INST`, default `RESET_PC`.
  - State enum `if_state_t` {RUN, REDIRECT}.
  - Struct `if_id_t` {inst, pc_4, valid}.
- One sub-module, `if_id_reg`: the IF/ID register with hold, bubble-load and normal-load controls. `if_stage` keeps the PC, `redir_pc` and the FSM.

## Test plan

- Reset release, `imem_ready` tied 1, words 0x20010001, 0x20020002 → `imem_addr` sequence 0x0, 0x4, 0x8; `id_inst`/`id_pc_4` = 0x20010001/0x4, then 0x20020002/0x8.
- `stall`=1 for 3 cycles with IF/ID holding {0x8C220000, 0x10} → outputs unchanged for 3 cycles; the next fetch after release is from 0x10.
- RUN, `imem_ready`=1, `branch_taken`=1, target 0x100, without the macro → bubble (`id_valid`=0, `id_inst`=0); the next fetch is at 0x100. With the macro → the fetched word is valid in IF/ID.
- `branch_taken`=1 with target 0x200 while `imem_ready`=0, then ready 2 cycles later → `imem_addr` stays at the old PC until ready, then 0x200; the old word is squashed (without the macro).
- `pc`=0xFFFF_FFFC, ready → `id_pc_4`=0x0 and the next `imem_addr`=0x0.
- `rst_n` pulsed low during REDIRECT → all outputs reset immediately; fetch restarts at `RESET_PC`, not at `redir_pc`.
